digest_serializer: RTL and testbench
====================================

Name: digest_serializer

Overview:
Downstream stage of the hash controller. It captures the 512-bit digest from the Blake2 engine when digest_valid rises, optionally truncates it to OUT_BYTES, and returns it to the processor as BUS_WIDTH words over a valid/ready stream. It provides a busy flag so the controller can hold off the next hash request, and a sticky overrun flag for digests that arrive while a readout is still in progress.

Parameters:
BUS_WIDTH, 64, processor bus width in bits; must divide DIGEST_WIDTH.
DIGEST_WIDTH, 512, digest width delivered by the hash engine.
OUT_BYTES, 64, digest length returned in bytes, 1..DIGEST_WIDTH/8.

Ports:
clk  in  1  single clock; all logic on posedge.
reset_n  in  1  asynchronous, active-low reset.
digest  in  DIGEST_WIDTH  hash result from the engine; valid while digest_valid is high.
digest_valid  in  1  engine result flag; a rising edge marks a new digest.
flush  in  1  synchronous abort: discard the current digest and clear overrun.
dout  out  BUS_WIDTH  output word.
dout_valid  out  1  dout holds a word.
dout_ready  in  1  processor accepts the word when dout_valid and dout_ready are both high.
dout_last  out  1  high with the final word of a digest.
busy  out  1  a captured digest is not yet fully read.
overrun  out  1  sticky: a digest was dropped because busy was high.

Behaviour:
- Reset (async, reset_n low): state IDLE, dout=0, dout_valid=0, dout_last=0, busy=0, overrun=0, word index=0, capture register=0, dv_q=0.
- Reset asserted mid-readout aborts the readout; no words are emitted after release until a new rising edge.
- Edge detect: dv_q is digest_valid registered. rise = digest_valid & ~dv_q. A high digest_valid at reset release counts as a rise.
- NUM_WORDS = ceil(OUT_BYTES*8/BUS_WIDTH).
- Word k = capture[k*BUS_WIDTH +: BUS_WIDTH] (little-endian, word 0 = digest[BUS_WIDTH-1:0]).
- In word NUM_WORDS-1, bits at or above (OUT_BYTES*8 - k*BUS_WIDTH) are forced to 0.
- FSM states: IDLE, SEND.
- IDLE: on rise (with flush low), capture digest, index=0, go to SEND.
  - dout_valid rises in the cycle after the rise is sampled (1-cycle latency).
  - busy=1 from the same edge.
- SEND: dout, dout_valid=1 and dout_last=(index==NUM_WORDS-1) are held stable until the handshake completes.
  - On handshake with a non-last word: index+1, next word presented on the next cycle (one word per cycle sustained).
  - On handshake with the last word: return to IDLE. dout_valid=0, dout_last=0, busy=0 next cycle; dout keeps its last value.
- Rise while in SEND, except when the last word is being accepted in that same cycle: the new digest is dropped and overrun<=1. The current readout continues unaffected.
- Rise in the same cycle as the last-word handshake: the new digest is captured, index=0, the FSM stays in SEND. busy stays 1 and the next cycle presents word 0 of the new digest. overrun is not set.
- flush (any state): next cycle is IDLE with dout_valid=0, dout_last=0, busy=0, overrun=0. flush has priority over rise and over the handshake; a rise in the same cycle is discarded without setting overrun.
- dout_ready while dout_valid=0 is ignored.
- overrun clears only on reset or flush.

Test Plan:
- Default params: digest word k = 64'h1111_1111_1111_1111*(k+1), pulse digest_valid, dout_ready=1 -> 8 consecutive words 0x1111..., 0x2222..., ..., 0x8888... starting 1 cycle after the rise; dout_last only on the 8th; busy drops the cycle after.
- OUT_BYTES=20, digest=all ones -> 3 words: FFFF_FFFF_FFFF_FFFF, FFFF_FFFF_FFFF_FFFF, 0000_0000_FFFF_FFFF with dout_last on the 3rd.
- Backpressure: toggle dout_ready 1,0,0,1,... -> each word held stable while not accepted, no word skipped or duplicated, exactly 8 handshakes.
- Second rise after 3 words accepted -> overrun=1, remaining 5 words come from the first digest; then flush -> overrun=0, busy=0, dout_valid=0.
- Second rise in the same cycle as the last-word handshake -> overrun stays 0; word 0 of the new digest is presented the next cycle.
- reset_n pulsed low after 4 words -> all outputs 0 immediately; with digest_valid held low after release, no further dout_valid.

Source files
------------

// File: rtl/digest_serializer.sv
// Captures a hash digest on the rising edge of digest_valid and streams it out as
// BUS_WIDTH words over valid/ready, optionally truncated to OUT_BYTES.
module digest_serializer #(
  parameter int BUS_WIDTH    = 64,
  parameter int DIGEST_WIDTH = 512,
  parameter int OUT_BYTES    = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DIGEST_WIDTH-1:0] digest,
  input  logic                    digest_valid,
  input  logic                    flush,
  output logic [BUS_WIDTH-1:0]    dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    overrun
);

  localparam int TOTAL_WORDS = DIGEST_WIDTH / BUS_WIDTH;
  localparam int NUM_WORDS   = (OUT_BYTES * 8 + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int IDX_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam int LAST_BITS   = OUT_BYTES * 8 - (NUM_WORDS - 1) * BUS_WIDTH;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [BUS_WIDTH-1:0] LAST_MASK = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - LAST_BITS);

  typedef enum logic [0:0] {IDLE, SEND} state_t;
  typedef logic [TOTAL_WORDS-1:0][BUS_WIDTH-1:0] words_t;

  state_t               r_state, w_state_nxt;
  words_t               r_cap, w_cap_nxt;
  words_t               w_din;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt, w_idx_inc;
  logic [BUS_WIDTH-1:0] r_dout, w_dout_nxt;
  logic                 r_vld, w_vld_nxt;
  logic                 r_last, w_last_nxt;
  logic                 r_ovr, w_ovr_nxt;
  logic                 r_dv_q;
  logic                 w_rise, w_hs;

  // Bytes beyond OUT_BYTES in the final word read as zero.
  function automatic logic [BUS_WIDTH-1:0] trim(input logic [BUS_WIDTH-1:0] w,
                                                input logic [IDX_W-1:0]     k);
    return (k == LAST_IDX) ? (w & LAST_MASK) : w;
  endfunction

  assign w_din     = digest;
  assign w_rise    = digest_valid & ~r_dv_q;
  assign w_hs      = r_vld & dout_ready;
  assign w_idx_inc = r_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cap   <= '0;
      r_idx   <= '0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_ovr   <= 1'b0;
      r_dv_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cap   <= w_cap_nxt;
      r_idx   <= w_idx_nxt;
      r_dout  <= w_dout_nxt;
      r_vld   <= w_vld_nxt;
      r_last  <= w_last_nxt;
      r_ovr   <= w_ovr_nxt;
      r_dv_q  <= digest_valid;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_nxt   = r_cap;
    w_idx_nxt   = r_idx;
    w_dout_nxt  = r_dout;
    w_vld_nxt   = r_vld;
    w_last_nxt  = r_last;
    w_ovr_nxt   = r_ovr;
    if (flush) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
      w_vld_nxt   = 1'b0;
      w_last_nxt  = 1'b0;
      w_ovr_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_nxt = SEND;
            w_cap_nxt   = w_din;
            w_idx_nxt   = '0;
            w_dout_nxt  = trim(w_din[0], '0);
            w_vld_nxt   = 1'b1;
            w_last_nxt  = (LAST_IDX == '0);
          end
        end
        SEND: begin
          if (w_hs && r_last) begin
            // A digest arriving exactly as the last word leaves is taken back-to-back.
            if (w_rise) begin
              w_cap_nxt  = w_din;
              w_idx_nxt  = '0;
              w_dout_nxt = trim(w_din[0], '0);
              w_last_nxt = (LAST_IDX == '0);
            end else begin
              w_state_nxt = IDLE;
              w_vld_nxt   = 1'b0;
              w_last_nxt  = 1'b0;
            end
          end else begin
            if (w_hs) begin
              w_idx_nxt  = w_idx_inc;
              w_dout_nxt = trim(r_cap[w_idx_inc], w_idx_inc);
              w_last_nxt = (w_idx_inc == LAST_IDX);
            end
            if (w_rise) w_ovr_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_vld;
  assign dout_last  = r_last;
  assign busy       = (r_state == SEND);
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_digest_serializer.sv
// Bench for digest_serializer: vector tables plus hand sequences, words checked
// against a queue of expected outputs as the DUT hands them over.
module tb_digest_serializer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [511:0] dig, dig20;
  logic         dv, dv20, flush, flush20;
  logic [63:0]  dout, dout20;
  logic         vld, vld20, rdy, rdy20, last, last20;
  logic         busy, busy20, ovr, ovr20;

  typedef struct { logic [63:0] din; logic [63:0] dexp; logic dlast; } vec_t;
  typedef struct { logic [63:0] d; logic l; } exp_t;

  vec_t v64[8];
  vec_t v20[8];
  exp_t q64[$];
  exp_t q20[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   hs20   = 0;
  logic        p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
  logic [63:0] p_dout = '0;

  always #5 clk = ~clk;

  digest_serializer u_dut (
    .clk(clk), .reset_n(reset_n), .digest(dig), .digest_valid(dv), .flush(flush),
    .dout(dout), .dout_valid(vld), .dout_ready(rdy), .dout_last(last),
    .busy(busy), .overrun(ovr)
  );

  digest_serializer #(.OUT_BYTES(20)) u_dut20 (
    .clk(clk), .reset_n(reset_n), .digest(dig20), .digest_valid(dv20), .flush(flush20),
    .dout(dout20), .dout_valid(vld20), .dout_ready(rdy20), .dout_last(last20),
    .busy(busy20), .overrun(ovr20)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mkword(input int s, input int k);
    logic [15:0] sv, kv;
    sv = 16'(s);
    kv = 16'(k);
    return {sv, 16'hC0DE, kv, 16'h5A5A};
  endfunction

  task automatic load_digest(input int s);
    for (int k = 0; k < 8; k++) dig[k*64 +: 64] = mkword(s, k);
  endtask

  task automatic push_words(input int s, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.d = mkword(s, k);
      e.l = (k == 7);
      q64.push_back(e);
    end
  endtask

  // Scoreboard + hold-stability monitor for the default instance.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && vld && p_vld && !p_rdy) begin
      chk("hold_dout", dout, p_dout);
      chk("hold_last", 64'(last), 64'(p_last));
    end
    if (vld && rdy) begin
      hs_cnt++;
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h, required no word", dout);
      end else begin
        e = q64.pop_front();
        chk("dout", dout, e.d);
        chk("dout_last", 64'(last), 64'(e.l));
      end
    end
    p_vld  = vld;
    p_rdy  = rdy;
    p_dout = dout;
    p_last = last;
  end

  always @(negedge clk) begin
    exp_t e;
    if (vld20 && rdy20) begin
      hs20++;
      if (q20.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word20: got %h, required no word", dout20);
      end else begin
        e = q20.pop_front();
        chk("dout20", dout20, e.d);
        chk("dout_last20", 64'(last20), 64'(e.l));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int   pat[4];
    exp_t e;
    pat = '{1, 0, 0, 1};
    for (int k = 0; k < 8; k++) begin
      v64[k].din   = 64'h1111_1111_1111_1111 * (k + 1);
      v64[k].dexp  = v64[k].din;
      v64[k].dlast = (k == 7);
      v20[k].din   = '1;
      v20[k].dexp  = (k == 2) ? 64'h0000_0000_FFFF_FFFF : '1;
      v20[k].dlast = (k == 2);
    end

    reset_n = 1'b0;
    dig = '0; dig20 = '0; dv = 0; dv20 = 0; flush = 0; flush20 = 0; rdy = 0; rdy20 = 0;
    #3;
    chk("rst_dout", dout, 64'h0);
    chk("rst_valid", 64'(vld), 64'h0);
    chk("rst_last", 64'(last), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_overrun", 64'(ovr), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick;

    // Default parameters: eight words back to back.
    for (int k = 0; k < 8; k++) begin
      dig[k*64 +: 64] = v64[k].din;
      e.d = v64[k].dexp;
      e.l = v64[k].dlast;
      q64.push_back(e);
    end
    hs_cnt = 0;
    rdy = 1;
    dv  = 1;
    tick;
    dv = 0;
    @(negedge clk);
    chk("t1_valid_latency", 64'(vld), 64'h1);
    chk("t1_busy", 64'(busy), 64'h1);
    repeat (8) tick;
    @(negedge clk);
    chk("t1_valid_drop", 64'(vld), 64'h0);
    chk("t1_busy_drop", 64'(busy), 64'h0);
    chk("t1_last_drop", 64'(last), 64'h0);
    chk("t1_dout_kept", dout, 64'h8888_8888_8888_8888);
    chk("t1_handshakes", 64'(hs_cnt), 64'd8);
    chk("t1_queue", 64'(q64.size()), 64'd0);

    // Truncated to 20 bytes.
    for (int k = 0; k < 8; k++) dig20[k*64 +: 64] = v20[k].din;
    for (int k = 0; k < 3; k++) begin
      e.d = v20[k].dexp;
      e.l = v20[k].dlast;
      q20.push_back(e);
    end
    rdy20 = 1;
    dv20  = 1;
    tick;
    dv20 = 0;
    repeat (4) tick;
    chk("t2_handshakes", 64'(hs20), 64'd3);
    chk("t2_busy", 64'(busy20), 64'h0);
    chk("t2_queue", 64'(q20.size()), 64'd0);

    // Backpressure with ready pattern 1,0,0,1.
    load_digest(1);
    push_words(1, 8);
    hs_cnt = 0;
    dv  = 1;
    rdy = pat[0][0];
    for (int c = 0; c < 40; c++) begin
      tick;
      if (c == 0) dv = 0;
      rdy = pat[(c + 1) % 4][0];
    end
    rdy = 1;
    chk("t3_handshakes", 64'(hs_cnt), 64'd8);
    chk("t3_queue", 64'(q64.size()), 64'd0);
    chk("t3_busy", 64'(busy), 64'h0);

    // Second digest mid-readout is dropped; then flush clears overrun.
    load_digest(2);
    push_words(2, 8);
    dv = 1;
    tick;
    dv = 0;
    repeat (3) tick;
    load_digest(3);
    dv = 1;
    tick;
    dv = 0;
    @(negedge clk);
    chk("t4_overrun_set", 64'(ovr), 64'h1);
    chk("t4_busy", 64'(busy), 64'h1);
    repeat (4) tick;
    @(negedge clk);
    chk("t4_idle", 64'(busy), 64'h0);
    chk("t4_overrun_sticky", 64'(ovr), 64'h1);
    chk("t4_queue", 64'(q64.size()), 64'd0);
    flush = 1;
    tick;
    flush = 0;
    @(negedge clk);
    chk("t4_flush_overrun", 64'(ovr), 64'h0);
    chk("t4_flush_busy", 64'(busy), 64'h0);
    chk("t4_flush_valid", 64'(vld), 64'h0);

    // Flush mid-readout together with a rise: both discarded.
    load_digest(4);
    push_words(4, 2);
    dv = 1;
    tick;
    dv = 0;
    repeat (2) tick;
    flush = 1;
    dv    = 1;
    rdy   = 0;
    tick;
    flush = 0;
    dv    = 0;
    rdy   = 1;
    @(negedge clk);
    chk("t5_valid", 64'(vld), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_overrun", 64'(ovr), 64'h0);
    repeat (5) tick;
    chk("t5_quiet", 64'(vld), 64'h0);
    chk("t5_queue", 64'(q64.size()), 64'd0);

    // Rise coincident with last-word handshake: captured back-to-back.
    load_digest(5);
    push_words(5, 8);
    push_words(6, 8);
    dv = 1;
    tick;
    dv = 0;
    repeat (7) tick;
    load_digest(6);
    dv = 1;
    tick;
    dv = 0;
    @(negedge clk);
    chk("t6_overrun", 64'(ovr), 64'h0);
    chk("t6_valid", 64'(vld), 64'h1);
    chk("t6_busy", 64'(busy), 64'h1);
    repeat (8) tick;
    @(negedge clk);
    chk("t6_idle", 64'(busy), 64'h0);
    chk("t6_queue", 64'(q64.size()), 64'd0);

    // Asynchronous reset mid-readout.
    load_digest(7);
    push_words(7, 4);
    dv = 1;
    tick;
    dv = 0;
    repeat (4) tick;
    reset_n = 1'b0;
    #1;
    chk("t7_dout", dout, 64'h0);
    chk("t7_valid", 64'(vld), 64'h0);
    chk("t7_last", 64'(last), 64'h0);
    chk("t7_busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    hs_cnt = 0;
    repeat (10) tick;
    chk("t7_no_words", 64'(hs_cnt), 64'd0);
    chk("t7_valid_after", 64'(vld), 64'h0);
    chk("t7_queue", 64'(q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
